io_input_responder: RTL and testbench
=====================================

Name: io_input_responder

Overview:
Memory-mapped responder for the core's load/store path, at the far end of the LSU request from the initiator side. It samples the board switches and push-buttons through a synchronizer and debouncer. It exposes four word registers at BASE_ADDR and answers each accepted request one cycle later with an acknowledge and registered read data. It also keeps sticky button-press flags that software clears by writing 1 to them, and raises a level interrupt while any flag is set.

Parameters:
BASE_ADDR, 32'h0000_7800, byte base of the 16-byte register window; bits [3:0] must be 0.
SW_W, 32, switch input width (1..32).
BTN_W, 4, button input width (1..16).
DB_RESET, 16'd50000, reset value of the debounce sample period, in clocks.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_io_sw  in  SW_W  raw switches, asynchronous to i_clk.
i_io_btn  in  BTN_W  raw buttons, asynchronous to i_clk, active-high.
i_lsu_req  in  1  request valid this cycle.
i_lsu_wren  in  1  1 = write, 0 = read; qualified by i_lsu_req.
i_lsu_addr  in  32  byte address.
i_st_data  in  32  write data; full word only.
o_hit  out  1  combinational: i_lsu_addr[31:4] == BASE_ADDR[31:4].
o_ack  out  1  registered one-cycle pulse, cycle after an accepted request.
o_ld_data  out  32  registered read data; 0 whenever o_ack = 0.
o_irq  out  1  registered: OR of the EDGE flags.

Behaviour:
- Reset: o_ack = 0, o_ld_data = 0, o_irq = 0, sync and debounced state = 0, EDGE = 0, DB_PERIOD = DB_RESET, prescaler = 0.
- Register map, word offset i_lsu_addr[3:2]:
  - 0: SW. RO. Debounced switches, zero-extended.
  - 1: BTN. RO. Debounced buttons, zero-extended.
  - 2: EDGE. Read returns the flags; write-1-to-clear per bit.
  - 3: CTRL. RW. [15:0] = DB_PERIOD; reads return zeros above bit 15.
- Address bits [1:0] are ignored. Sub-word stores are not supported; the initiator merges sub-word stores before issuing them.
- Handshake:
  - A request is accepted in cycle N when i_lsu_req & o_hit.
  - In N+1: o_ack = 1. For a read, o_ld_data holds the register value as sampled at the N edge. For a write, o_ld_data = 0.
  - Back-to-back requests are accepted every cycle; there is no backpressure.
  - A request with o_hit = 0 produces no ack and no state change.
  - Writes to SW or BTN are acked and ignored.
- Synchronizer: two flops per input bit; the debounce logic sees only the second flop.
- Debounce:
  - A shared prescaler counts 0..max(DB_PERIOD,1)-1 and emits a tick on its terminal count, then wraps to 0.
  - On each tick, each bit stores the synchronized value in a sample register. The debounced bit updates only when the new sample equals the previous sample.
  - Result: a change must be stable for two consecutive ticks; worst-case latency is 2 + 2*period clocks.
  - Writing CTRL clears the prescaler in the cycle the write is accepted. DB_PERIOD = 0 behaves as 1 (tick every clock).
- EDGE:
  - A bit sets on a debounced BTN 0->1 transition.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
  - Bits above BTN_W read 0.
  - o_irq = |EDGE, registered, so it reflects flags as of the previous edge.
- Reset mid-operation: asynchronous clear of all state. A pending ack is dropped and the initiator must reissue.
- Counter arithmetic: 16-bit unsigned, no overflow possible because compares use >=.

Decomposition:
- Shared package io_resp_pkg:
  - offset constants OFF_SW = 2'd0, OFF_BTN = 2'd1, OFF_EDGE = 2'd2, OFF_CTRL = 2'd3;
  - the default base address;
  - typedef db_period_t = logic [15:0].
- One sub-module, io_debounce: parameter W, with inputs i_clk, i_rst_n, i_tick, i_raw[W] and output o_db[W]. It contains the synchronizer, sample register and agreement logic, and is instanced twice (switches and buttons). The prescaler and register file stay in the top.

Test Plan:
- Reset, then read offsets 0/4/8/0xC at BASE -> acks in N+1 with 0, 0, 0, 50000. Address BASE+0x10 with i_lsu_req = 1 -> o_hit = 0, no ack.
- Write CTRL = 4, set i_io_sw = 32'hA5A5_0F0F -> SW reads 0 until stable for 2 ticks; reads 32'hA5A5_0F0F no later than 2 + 8 clocks after the change.
- Button glitch: with period 4, i_io_btn[0] high for 3 clocks -> BTN stays 0, EDGE stays 0, o_irq stays 0.
- Clean press of btn[2] -> BTN = 4'b0100, EDGE = 4'b0100, o_irq = 1. Write EDGE with 32'h4 -> EDGE = 0, o_irq = 0 one cycle later.
- Debounced rising edge of btn[1] in the same cycle as a W1C write of 32'h2 -> EDGE[1] stays 1.
- Back-to-back: read SW, write CTRL = 0, read CTRL in consecutive cycles -> three consecutive ack pulses, CTRL reads 0, tick asserted every clock. Assert i_rst_n low between the request and its ack -> no ack, all registers at reset values.

Source files
------------

// File: rtl/io_resp_pkg.sv
// io_resp_pkg: shared definitions for the memory-mapped switch/button responder.
//
// Contents:
//   OFF_SW / OFF_BTN / OFF_EDGE / OFF_CTRL  word offsets (address bits [3:2])
//   DEFAULT_BASE_ADDR                       default byte base of the 16-byte window
//   DEFAULT_DB_PERIOD                       default debounce sample period in clocks
//   db_period_t                             debounce period / prescaler type
//   db_terminal()                           terminal prescaler count for a period

package io_resp_pkg;

   localparam logic [1:0] OFF_SW   = 2'd0;
   localparam logic [1:0] OFF_BTN  = 2'd1;
   localparam logic [1:0] OFF_EDGE = 2'd2;
   localparam logic [1:0] OFF_CTRL = 2'd3;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7800;
   localparam logic [15:0] DEFAULT_DB_PERIOD = 16'd50000;

   typedef logic [15:0] db_period_t;

   // Last count value of the prescaler. A period of 0 is treated as 1, so
   // both give a terminal count of 0 and a tick on every clock.
   function automatic db_period_t db_terminal(input db_period_t period);
      db_terminal = (period == 16'd0) ? 16'd0 : period - 16'd1;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchronizer followed by a tick-sampled agreement filter.
//
// Each bit is sampled into a sample register on every i_tick. The debounced
// output takes the new sample only when it equals the previous sample, so a
// level must be seen on two consecutive ticks before it is passed on.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_tick   sample strobe from the shared prescaler
//   i_raw    raw asynchronous inputs (W bits)
//   o_db     debounced outputs (W bits, registered)

module io_debounce #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_tick,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_db
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] sample_q;
   logic [W-1:0] sample_d;
   logic [W-1:0] db_q;
   logic [W-1:0] db_d;
   logic [W-1:0] agree;

   always_comb begin
      agree    = ~(sync2_q ^ sample_q);
      sample_d = sample_q;
      db_d     = db_q;
      if (i_tick) begin
         sample_d = sync2_q;
         // Bits whose new sample matches the previous one take the new value;
         // the others hold their debounced state.
         db_d = (agree & sync2_q) | (~agree & db_q);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sample_q <= '0;
         db_q     <= '0;
      end else begin
         sync1_q  <= i_raw;
         sync2_q  <= sync1_q;
         sample_q <= sample_d;
         db_q     <= db_d;
      end
   end

   assign o_db = db_q;

endmodule

// File: rtl/io_input_responder.sv
// io_input_responder: load/store responder exposing debounced switches and buttons.
//
// Register window (16 bytes at BASE_ADDR, word offset = i_lsu_addr[3:2]):
//   0 SW    RO   debounced switches, zero-extended
//   1 BTN   RO   debounced buttons, zero-extended
//   2 EDGE  W1C  sticky button-press flags
//   3 CTRL  RW   [15:0] debounce sample period in clocks
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_io_sw     raw switches (SW_W bits, asynchronous)
//   i_io_btn    raw buttons (BTN_W bits, asynchronous, active-high)
//   i_lsu_req   request valid
//   i_lsu_wren  1 = write, 0 = read
//   i_lsu_addr  byte address
//   i_st_data   write data (full word)
//   o_hit       combinational address match on the 16-byte window
//   o_ack       one-cycle acknowledge, cycle after an accepted request
//   o_ld_data   read data, zero unless acking a read
//   o_irq       level interrupt while any EDGE flag is set

module io_input_responder
   import io_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned SW_W      = 32,
   parameter int unsigned BTN_W     = 4,
   parameter db_period_t  DB_RESET  = DEFAULT_DB_PERIOD
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [SW_W-1:0]  i_io_sw,
   input  logic [BTN_W-1:0] i_io_btn,
   input  logic             i_lsu_req,
   input  logic             i_lsu_wren,
   input  logic [31:0]      i_lsu_addr,
   input  logic [31:0]      i_st_data,
   output logic             o_hit,
   output logic             o_ack,
   output logic [31:0]      o_ld_data,
   output logic             o_irq
);

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic       accept;
   logic       rd_accept;
   logic       wr_ctrl;
   logic       wr_flags;
   logic [1:0] offset;

   assign o_hit     = (i_lsu_addr[31:4] == BASE_ADDR[31:4]);
   assign accept    = i_lsu_req & o_hit;
   assign rd_accept = accept & ~i_lsu_wren;
   assign offset    = i_lsu_addr[3:2];
   assign wr_ctrl   = accept & i_lsu_wren & (offset == OFF_CTRL);
   assign wr_flags  = accept & i_lsu_wren & (offset == OFF_EDGE);

   // Byte lanes and upper store bits that no register consumes.
   logic unused_bits;
   assign unused_bits = ^{i_lsu_addr[1:0], i_st_data[31:16]};

   // ---------------------------------------------------------------------
   // Debounce prescaler
   // ---------------------------------------------------------------------
   db_period_t period_q;
   db_period_t pres_q;
   db_period_t pres_d;
   logic       tick;

   always_comb begin
      // >= rather than == so a period shrunk below the current count still wraps.
      tick   = (pres_q >= db_terminal(period_q));
      pres_d = pres_q + 16'd1;
      if (tick || wr_ctrl) begin
         pres_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   logic [SW_W-1:0]  sw_db;
   logic [BTN_W-1:0] btn_db;

   io_debounce #(
      .W (SW_W)
   ) u_sw_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (tick),
      .i_raw   (i_io_sw),
      .o_db    (sw_db)
   );

   io_debounce #(
      .W (BTN_W)
   ) u_btn_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (tick),
      .i_raw   (i_io_btn),
      .o_db    (btn_db)
   );

   // ---------------------------------------------------------------------
   // Button press flags
   // ---------------------------------------------------------------------
   logic [BTN_W-1:0] btn_prev_q;
   logic [BTN_W-1:0] flags_q;
   logic [BTN_W-1:0] flags_d;
   logic [BTN_W-1:0] rise;
   logic [BTN_W-1:0] clr;

   always_comb begin
      rise = btn_db & ~btn_prev_q;
      clr  = wr_flags ? i_st_data[BTN_W-1:0] : '0;
      // Set is applied after clear so a same-cycle press is never lost.
      flags_d = (flags_q & ~clr) | rise;
   end

   // ---------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      unique case (offset)
         OFF_SW:   rdata = 32'(sw_db);
         OFF_BTN:  rdata = 32'(btn_db);
         OFF_EDGE: rdata = 32'(flags_q);
         OFF_CTRL: rdata = 32'(period_q);
      endcase
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         period_q   <= DB_RESET;
         pres_q     <= '0;
         btn_prev_q <= '0;
         flags_q    <= '0;
         o_ack      <= 1'b0;
         o_ld_data  <= '0;
         o_irq      <= 1'b0;
      end else begin
         pres_q     <= pres_d;
         btn_prev_q <= btn_db;
         flags_q    <= flags_d;
         o_ack      <= accept;
         o_ld_data  <= rd_accept ? rdata : 32'd0;
         o_irq      <= |flags_q;
         if (wr_ctrl) begin
            period_q <= i_st_data[15:0];
         end
      end
   end

endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder: directed and randomized bench for io_input_responder.
// Expected values come from a cycle-level behavioural model kept in the bench.

module tb_io_input_responder;
   import io_resp_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_7800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] sw = '0;
   logic [3:0]  btn = '0;
   logic        req = 1'b0;
   logic        wren = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] st = '0;
   logic        hit;
   logic        ack;
   logic [31:0] ld;
   logic        irq;

   io_input_responder #(
      .BASE_ADDR (BASE),
      .SW_W      (32),
      .BTN_W     (4),
      .DB_RESET  (16'd50000)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_io_sw    (sw),
      .i_io_btn   (btn),
      .i_lsu_req  (req),
      .i_lsu_wren (wren),
      .i_lsu_addr (addr),
      .i_st_data  (st),
      .o_hit      (hit),
      .o_ack      (ack),
      .o_ld_data  (ld),
      .o_irq      (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [31:0] m_sw_hist[$];   // [0] = one clock old, [1] = two clocks old
   logic [3:0]  m_btn_hist[$];
   logic [31:0] m_sw_smp, m_sw_db;
   logic [3:0]  m_btn_smp, m_btn_db, m_btn_prev, m_flags;
   logic [15:0] m_period;
   int          m_elapsed;      // clocks since the sample clock was last restarted
   logic        m_ack, m_irq;
   logic [31:0] m_ld;

   task automatic model_reset();
      m_sw_hist  = {32'd0, 32'd0};
      m_btn_hist = {4'd0, 4'd0};
      m_sw_smp   = '0;
      m_sw_db    = '0;
      m_btn_smp  = '0;
      m_btn_db   = '0;
      m_btn_prev = '0;
      m_flags    = '0;
      m_period   = 16'd50000;
      m_elapsed  = 0;
      m_ack      = 1'b0;
      m_irq      = 1'b0;
      m_ld       = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] off);
      case (off)
         2'd0:    return m_sw_db;
         2'd1:    return {28'd0, m_btn_db};
         2'd2:    return {28'd0, m_flags};
         default: return {16'd0, m_period};
      endcase
   endfunction

   // One clock: drive a request, predict the edge, compare the outputs after it.
   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic        acc;
      logic        tick;
      logic [1:0]  off;
      int          p;
      logic [31:0] sw_old2, sw_now, n_sw_smp, n_sw_db, n_ld;
      logic [3:0]  btn_old2, btn_now, n_btn_smp, n_btn_db, n_flags, clr;
      logic [15:0] n_period;
      int          n_elapsed;
      logic        n_irq;

      req  = r;
      wren = w;
      addr = a;
      st   = d;
      #1;
      check_val("hit", {31'd0, hit}, {31'd0, (a[31:4] == BASE[31:4])});

      acc      = r && (a[31:4] == BASE[31:4]);
      off      = a[3:2];
      p        = (m_period == 16'd0) ? 1 : int'(m_period);
      tick     = ((m_elapsed % p) == p - 1);
      sw_now   = sw;
      btn_now  = btn;
      sw_old2  = m_sw_hist[1];
      btn_old2 = m_btn_hist[1];

      n_sw_smp  = m_sw_smp;
      n_sw_db   = m_sw_db;
      n_btn_smp = m_btn_smp;
      n_btn_db  = m_btn_db;
      if (tick) begin
         // A bit is accepted once two consecutive samples agree.
         for (int i = 0; i < 32; i++) if (sw_old2[i] == m_sw_smp[i]) n_sw_db[i] = sw_old2[i];
         for (int i = 0; i < 4; i++) if (btn_old2[i] == m_btn_smp[i]) n_btn_db[i] = btn_old2[i];
         n_sw_smp  = sw_old2;
         n_btn_smp = btn_old2;
      end

      clr     = (acc && w && off == 2'd2) ? d[3:0] : 4'd0;
      n_flags = (m_flags & ~clr) | (m_btn_db & ~m_btn_prev);
      n_irq   = (m_flags != 4'd0);
      n_ld    = (acc && !w) ? m_read(off) : 32'd0;
      if (acc && w && off == 2'd3) begin
         n_period  = d[15:0];
         n_elapsed = 0;
      end else begin
         n_period  = m_period;
         n_elapsed = m_elapsed + 1;
      end

      @(posedge clk);
      #1;
      m_sw_hist.push_front(sw_now);
      void'(m_sw_hist.pop_back());
      m_btn_hist.push_front(btn_now);
      void'(m_btn_hist.pop_back());
      m_btn_prev = m_btn_db;
      m_sw_smp   = n_sw_smp;
      m_sw_db    = n_sw_db;
      m_btn_smp  = n_btn_smp;
      m_btn_db   = n_btn_db;
      m_flags    = n_flags;
      m_period   = n_period;
      m_elapsed  = n_elapsed;
      m_ack      = acc;
      m_ld       = n_ld;
      m_irq      = n_irq;

      check_val("ack", {31'd0, ack}, {31'd0, m_ack});
      check_val("ld_data", ld, m_ld);
      check_val("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      logic        found;
      logic [1:0]  roff;
      logic [31:0] raddr, rdata;
      logic        rreq, rwr;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("rst_ack", {31'd0, ack}, 32'd0);
      check_val("rst_ld", ld, 32'd0);
      check_val("rst_irq", {31'd0, irq}, 32'd0);

      // Reset values of the four registers, then a miss just past the window.
      step(1'b1, 1'b0, BASE + 32'h0, 32'd0);
      check_val("rst_sw", ld, 32'd0);
      step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      check_val("rst_btn", ld, 32'd0);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("rst_edge", ld, 32'd0);
      step(1'b1, 1'b0, BASE + 32'hC, 32'd0);
      check_val("rst_ctrl", ld, 32'd50000);
      check_val("rst_ctrl_ack", {31'd0, ack}, 32'd1);
      step(1'b1, 1'b0, BASE + 32'h10, 32'd0);
      check_val("miss_ack", {31'd0, ack}, 32'd0);

      // Switch settle with period 4.
      step(1'b1, 1'b1, BASE + 32'hC, 32'd4);
      sw = 32'hA5A5_0F0F;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, BASE + 32'h0, 32'd0);
      check_val("sw_settled", ld, 32'hA5A5_0F0F);

      // Short glitch on btn[0] must not reach BTN or EDGE.
      btn = 4'b0001;
      idle(3);
      btn = 4'b0000;
      idle(12);
      step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      check_val("glitch_btn", ld, 32'd0);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("glitch_edge", ld, 32'd0);
      check_val("glitch_irq", {31'd0, irq}, 32'd0);

      // Clean press of btn[2], then clear it.
      btn = 4'b0100;
      idle(14);
      step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
      check_val("press_btn", ld, 32'h4);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("press_edge", ld, 32'h4);
      check_val("press_irq", {31'd0, irq}, 32'd1);
      step(1'b1, 1'b1, BASE + 32'h8, 32'h4);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("clr_edge", ld, 32'd0);
      check_val("clr_irq", {31'd0, irq}, 32'd0);

      // btn[1] rising edge in the same cycle as its W1C write: set wins.
      btn   = 4'b0110;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_btn_db[1] && !m_btn_prev[1]) found = 1'b1;
         else idle(1);
      end
      check_val("rise_found", {31'd0, found}, 32'd1);
      step(1'b1, 1'b1, BASE + 32'h8, 32'h2);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("set_wins", ld & 32'h2, 32'h2);

      // Back-to-back requests.
      step(1'b1, 1'b0, BASE + 32'h0, 32'd0);
      check_val("b2b_ack0", {31'd0, ack}, 32'd1);
      step(1'b1, 1'b1, BASE + 32'hC, 32'd0);
      check_val("b2b_ack1", {31'd0, ack}, 32'd1);
      step(1'b1, 1'b0, BASE + 32'hC, 32'd0);
      check_val("b2b_ack2", {31'd0, ack}, 32'd1);
      check_val("b2b_ctrl", ld, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) sw = $urandom();
         if ($urandom_range(0, 19) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, 3));
         rreq = ($urandom_range(0, 9) < 7);
         rwr  = ($urandom_range(0, 9) < 3);
         roff = 2'($urandom_range(0, 3));
         raddr = BASE + {28'd0, roff, 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 9) == 0) raddr = BASE + 32'h10 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) raddr = $urandom();
         rdata = $urandom();
         if (roff == 2'd3) rdata[15:0] = 16'($urandom_range(0, 5));
         step(rreq, rwr, raddr, rdata);
      end

      // Reset between a request and its ack drops the ack.
      req  = 1'b1;
      wren = 1'b0;
      addr = BASE + 32'hC;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("mid_rst_ack", {31'd0, ack}, 32'd0);
      check_val("mid_rst_ld", ld, 32'd0);
      check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
      req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 1'b0, BASE + 32'hC, 32'd0);
      check_val("post_rst_ctrl", ld, 32'd50000);
      step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
      check_val("post_rst_edge", ld, 32'd0);
      step(1'b1, 1'b0, BASE + 32'h0, 32'd0);
      check_val("post_rst_sw", ld, 32'd0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
